// File: rtl/instr_cache_if.sv
// Fetch-side (CPU <-> cache) and memory-side (cache <-> instruction memory) bundles
// for the direct-mapped instruction cache.
interface instr_fetch_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] instruction;
  logic            busywait;

  modport master (output pc, input instruction, input busywait);
  modport slave  (input pc, output instruction, output busywait);
endinterface

interface instr_mem_if #(
  parameter int unsigned BADDR_W = 6,
  parameter int unsigned LINE_W  = 128
);
  logic               read;
  logic [BADDR_W-1:0] address;
  logic [LINE_W-1:0]  readdata;
  logic               busywait;

  modport master (output read, output address, input readdata, input busywait);
  modport slave  (input read, input address, output readdata, output busywait);
endinterface

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache: combinational hit path, whole-line
// refill from a block-wide memory on a miss, CPU stalled via busywait meanwhile.
module instr_cache #(
  parameter int unsigned BLOCKS    = 8,
  parameter int unsigned WORDS     = 4,
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic clk,
  input  logic rst_n,
  instr_fetch_if.slave fetch_if,
  instr_mem_if.master  mem_if
);

  localparam int unsigned IDX_W   = $clog2(BLOCKS);
  localparam int unsigned OFF_W   = $clog2(WORDS);
  localparam int unsigned BADDR_W = ADDR_BITS - OFF_W - 2;
  localparam int unsigned TAG_W   = BADDR_W - IDX_W;
  localparam int unsigned IDX_LSB = OFF_W + 2;

  typedef enum logic [1:0] {IDLE, FETCH, UPDATE} state_e;

  state_e               state_q, state_d;
  logic                 mem_read_q, mem_read_d;
  logic [BADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [BLOCKS-1:0]    valid_q;
  logic [TAG_W-1:0]     tag_q  [BLOCKS];
  logic [WORDS-1:0][31:0] data_q [BLOCKS];

  logic [IDX_W-1:0]     pc_idx;
  logic [TAG_W-1:0]     pc_tag;
  logic [OFF_W-1:0]     pc_off;
  logic [BADDR_W-1:0]   pc_baddr;
  logic [IDX_W-1:0]     fill_idx;
  logic [TAG_W-1:0]     fill_tag;
  logic                 hit_c;
  logic                 fill_we_c;
  logic                 unused_pc_bits;

  assign pc_baddr = fetch_if.pc[ADDR_BITS-1:IDX_LSB];
  assign pc_idx   = pc_baddr[IDX_W-1:0];
  assign pc_tag   = pc_baddr[BADDR_W-1:IDX_W];
  assign pc_off   = fetch_if.pc[IDX_LSB-1:2];
  assign unused_pc_bits = ^{fetch_if.pc[31:ADDR_BITS], fetch_if.pc[1:0]};

  // The latched block address already holds the fill index and tag.
  assign fill_idx = mem_addr_q[IDX_W-1:0];
  assign fill_tag = mem_addr_q[BADDR_W-1:IDX_W];

  assign hit_c = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);

  // Fetch outputs are combinational and forced low while reset is asserted.
  assign fetch_if.busywait    = rst_n && ((state_q != IDLE) || !hit_c);
  assign fetch_if.instruction = rst_n ? data_q[pc_idx][pc_off] : 32'(0);

  assign mem_if.read    = mem_read_q;
  assign mem_if.address = mem_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mem_read_q <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_read_q <= mem_read_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_read_d = mem_read_q;
    mem_addr_d = mem_addr_q;
    fill_we_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!hit_c) begin
          state_d    = FETCH;
          mem_read_d = 1'b1;
          mem_addr_d = pc_baddr;
        end
      end
      FETCH: begin
        if (!mem_if.busywait) begin
          fill_we_c  = 1'b1;
          mem_read_d = 1'b0;
          state_d    = UPDATE;
        end
      end
      UPDATE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Only valid bits need reset; a reset mid-fill leaves the line invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (fill_we_c) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we_c) begin
      data_q[fill_idx] <= mem_if.readdata;
      tag_q[fill_idx]  <= fill_tag;
    end
  end

endmodule

// File: tb/tb_instr_cache.sv
// Directed bench for instr_cache with a variable-latency block memory model and
// a queue of expected instructions checked when the cache stops stalling.
module tb_instr_cache;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_if fif ();
  instr_mem_if   mif ();

  instr_cache dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .fetch_if (fif.slave),
    .mem_if   (mif.master)
  );

  int unsigned lat = 4;
  int unsigned mcnt = 0;
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic        mv [8];
  logic [2:0]  mt [8];

  function automatic logic [127:0] blk(input logic [5:0] a);
    logic [127:0] r;
    for (int w = 0; w < 4; w++) r[w*32 +: 32] = {8'hA5, 2'b00, a, 8'(w), 8'h3C};
    return r;
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] addr);
    logic [127:0] b;
    b = blk(addr[9:4]);
    return b[{addr[3:2], 5'b0} +: 32];
  endfunction

  always @(posedge clk) mcnt <= mif.read ? mcnt + 1 : 0;
  assign mif.busywait = mif.read && (mcnt < lat);
  assign mif.readdata = blk(mif.address);

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one fetch, wait for the stall to end and check timing, memory request and data.
  task automatic fetch(input logic [31:0] addr);
    logic [2:0] idx, tag;
    logic hit, done, rd_at_done;
    int stall, first_rd, rd_cycles, exp_stall;
    logic [5:0] seen_addr;
    logic [31:0] exp;
    idx = addr[6:4];
    tag = addr[9:7];
    hit = mv[idx] && (mt[idx] == tag);
    exp_stall = hit ? 0 : 3 + int'(lat);
    exp_q.push_back(word_of(addr));
    if (!hit) begin
      mv[idx] = 1'b1;
      mt[idx] = tag;
    end
    fif.pc = addr;
    stall = 0; first_rd = -1; rd_cycles = 0; seen_addr = '0; done = 1'b0; rd_at_done = 1'b0;
    while (!done && stall < 200) begin
      @(negedge clk);
      if (!fif.busywait) begin
        done = 1'b1;
        rd_at_done = mif.read;
      end else begin
        if (mif.read) begin
          if (first_rd < 0) first_rd = stall;
          rd_cycles++;
          seen_addr = mif.address;
        end
        stall++;
        @(posedge clk); #1;
      end
    end
    chk($sformatf("done@%0h", addr), done, 1'b1);
    chk($sformatf("stall@%0h", addr), stall, exp_stall);
    if (!hit) begin
      chk($sformatf("rd_start@%0h", addr), first_rd, 1);
      chk($sformatf("rd_len@%0h", addr), rd_cycles, lat + 1);
      chk($sformatf("maddr@%0h", addr), seen_addr, addr[9:4]);
    end else begin
      chk($sformatf("hit_noread@%0h", addr), rd_at_done, 1'b0);
    end
    exp = exp_q.pop_front();
    chk($sformatf("instr@%0h", addr), fif.instruction, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [5:0] first_addr, last_addr;
    logic done;
    int stall;
    for (int i = 0; i < 8; i++) begin mv[i] = 1'b0; mt[i] = '0; end
    fif.pc = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", fif.busywait, 1'b0);
    chk("rst_instr", fif.instruction, 32'h0);
    chk("rst_mread", mif.read, 1'b0);
    chk("rst_maddr", mif.address, 6'h0);
    rst_n = 1'b1;

    // Cold miss, sequential hits, aliasing, conflict
    fetch(32'h0);
    fetch(32'h4);
    fetch(32'h8);
    fetch(32'hC);
    fetch(32'h400);
    fetch(32'h80);
    fetch(32'h0);

    // Zero-wait memory
    lat = 0;
    fetch(32'h3F0);
    fetch(32'h3FC);

    // Reset pulsed mid-FETCH
    lat = 4;
    fetch(32'h10);
    fif.pc = 32'hA0;
    @(posedge clk); #1;
    chk("mid_mread", mif.read, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("async_mread", mif.read, 1'b0);
    chk("async_busy", fif.busywait, 1'b0);
    chk("async_instr", fif.instruction, 32'h0);
    chk("async_maddr", mif.address, 6'h0);
    for (int i = 0; i < 8; i++) mv[i] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    fetch(32'hA0);
    fetch(32'h10);

    // PC changed during a stall: first fill goes to line 5, then new PC misses
    lat = 2;
    exp_q.push_back(word_of(32'hE0));
    fif.pc = 32'h50;
    stall = 0; done = 1'b0; first_addr = '1; last_addr = '0;
    while (!done && stall < 200) begin
      @(negedge clk);
      if (!fif.busywait) begin
        done = 1'b1;
      end else begin
        if (mif.read) begin
          if (first_addr == 6'h3F) first_addr = mif.address;
          last_addr = mif.address;
        end
        stall++;
        @(posedge clk); #1;
        if (stall == 2) fif.pc = 32'hE0;
      end
    end
    chk("chg_done", done, 1'b1);
    chk("chg_stall", stall, 10);
    chk("chg_first_addr", first_addr, 6'h05);
    chk("chg_last_addr", last_addr, 6'h0E);
    chk("chg_instr", fif.instruction, exp_q.pop_front());
    mv[5] = 1'b1; mt[5] = 3'd0;
    mv[6] = 1'b1; mt[6] = 3'd1;
    @(posedge clk); #1;
    fetch(32'h54);
    fetch(32'hE8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
